// File: rtl/tlul_pkg.sv
// Minimal TL-UL type definitions shared by the SRAM device and its host.
package tlul_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef logic [3:0] tl_a_user_t;
    typedef logic [3:0] tl_d_user_t;

    localparam tl_d_user_t TL_D_USER_DEFAULT = '0;

    typedef struct packed {
        logic        a_valid;
        tl_a_op_e    a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        tl_a_user_t  a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        tl_d_op_e    d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        tl_d_user_t  d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_sram_dev_pkg.sv
// Response-entry type and A-channel request legality check for the SRAM device.
package tlul_sram_dev_pkg;
    import tlul_pkg::*;

    typedef struct packed {
        tl_d_op_e    d_opcode;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic [31:0] d_data;
        logic        d_error;
    } rsp_entry_t;

    // Returns 1 when a request must be answered with d_error and never reach the SRAM.
    function automatic logic tl_req_error(
        input tl_a_op_e    op,
        input logic [1:0]  size,
        input logic [31:0] addr,
        input logic [3:0]  mask,
        input int unsigned depth_words
    );
        logic [3:0] lane_win;
        logic       err;
        err = 1'b0;
        lane_win = 4'b0000;
        if (!(op == Get || op == PutFullData || op == PutPartialData)) begin
            err = 1'b1;
        end
        case (size)
            2'd0: lane_win = 4'b0001 << addr[1:0];
            2'd1: begin
                lane_win = addr[1] ? 4'b1100 : 4'b0011;
                if (addr[0]) err = 1'b1;
            end
            2'd2: begin
                lane_win = 4'b1111;
                if (addr[1:0] != 2'b00) err = 1'b1;
            end
            default: err = 1'b1;
        endcase
        if (64'(addr) >= 64'(depth_words) * 64'd4) begin
            err = 1'b1;
        end
        if ((mask & ~lane_win) != 4'b0000) begin
            err = 1'b1;
        end
        return err;
    endfunction

endpackage

// File: rtl/tlul_sram_dev_rspfifo.sv
// In-order response queue with fall-through: an entry pushed into an empty
// queue is visible on the output in the same cycle, giving one-cycle latency.
module tlul_sram_dev_rspfifo
    import tlul_sram_dev_pkg::*;
#(
    parameter int Depth = 2,
    localparam int CntW = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  rsp_entry_t      push_data_i,
    input  logic            ready_i,
    output logic            valid_o,
    output rsp_entry_t      data_o,
    output logic [CntW-1:0] count_o
);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    rsp_entry_t      mem_reg [Depth];
    logic [PtrW-1:0] wr_ptr_reg;
    logic [PtrW-1:0] rd_ptr_reg;
    logic [CntW-1:0] count_reg;
    logic            empty;
    logic            pop;
    logic            store;
    logic            deq;

    // Output selection: bypass the incoming entry when nothing is stored.
    always_comb begin
        empty   = (count_reg == '0);
        valid_o = !rst_i && (!empty || push_i);
        data_o  = empty ? push_data_i : mem_reg[rd_ptr_reg];
        pop     = valid_o && ready_i;
        store   = !rst_i && push_i && !(empty && pop);
        deq     = pop && !empty;
        count_o = count_reg;
    end

    // Pointer and occupancy bookkeeping; reset drops every queued entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (store) begin
                wr_ptr_reg <= (wr_ptr_reg == PtrW'(Depth - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (deq) begin
                rd_ptr_reg <= (rd_ptr_reg == PtrW'(Depth - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            if (store && !deq) begin
                count_reg <= count_reg + 1'b1;
            end else if (deq && !store) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    // Entry storage, no reset needed for payload.
    always_ff @(posedge clk_i) begin
        if (store) begin
            mem_reg[wr_ptr_reg] <= push_data_i;
        end
    end

    // a_ready accounting upstream must prevent pushing into a full queue.
    assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_i && (count_reg == CntW'(Depth))));

endmodule

// File: rtl/tlul_sram_dev.sv
// TL-UL device front end for a single-cycle-read SRAM with bounded outstanding requests.
module tlul_sram_dev
    import tlul_pkg::*;
    import tlul_sram_dev_pkg::*;
#(
    parameter int Depth       = 1024,
    parameter int Outstanding = 2,
    localparam int AW = $clog2(Depth)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  tlul_pkg::tl_h2d_t   tl_i,
    output tlul_pkg::tl_d2h_t   tl_o,
    output logic                req_o,
    output logic                we_o,
    output logic [AW-1:0]       addr_o,
    output logic [31:0]         wdata_o,
    output logic [31:0]         wmask_o,
    input  logic [31:0]         rdata_i
);
    localparam int CntW = $clog2(Outstanding + 1);

    logic            a_ready;
    logic            a_acc;
    logic            a_err;
    logic [CntW:0]   occupancy;
    logic [CntW-1:0] fifo_count;
    logic            rsp_valid;
    rsp_entry_t      rsp_head;
    rsp_entry_t      push_entry;
    logic            unused_tl;

    logic            infl_valid_reg;
    logic            infl_get_reg;
    logic [1:0]      infl_size_reg;
    logic [7:0]      infl_source_reg;
    logic            infl_err_reg;

    // Acceptance depends only on registered occupancy, never on d_ready.
    always_comb begin
        occupancy = {1'b0, fifo_count} + {{CntW{1'b0}}, infl_valid_reg};
        a_ready   = !rst_i && (occupancy < (CntW + 1)'(Outstanding));
        a_acc     = tl_i.a_valid && a_ready;
        a_err     = tl_req_error(tl_i.a_opcode, tl_i.a_size, tl_i.a_address,
                                 tl_i.a_mask, Depth);
        req_o     = a_acc && !a_err;
        we_o      = req_o && (tl_i.a_opcode != Get);
        addr_o    = tl_i.a_address[AW+1:2];
        wdata_o   = tl_i.a_data;
    end

    // Byte-lane mask expands to a bit mask for the SRAM.
    for (genvar gi = 0; gi < 4; gi++) begin : g_wmask
        assign wmask_o[gi*8 +: 8] = {8{tl_i.a_mask[gi]}};
    end

    assign unused_tl = ^{tl_i.a_param, tl_i.a_user};

    // Inflight stage waits the one cycle the SRAM needs to return read data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            infl_valid_reg  <= 1'b0;
            infl_get_reg    <= 1'b0;
            infl_size_reg   <= '0;
            infl_source_reg <= '0;
            infl_err_reg    <= 1'b0;
        end else begin
            infl_valid_reg <= a_acc;
            if (a_acc) begin
                infl_get_reg    <= (tl_i.a_opcode == Get);
                infl_size_reg   <= tl_i.a_size;
                infl_source_reg <= tl_i.a_source;
                infl_err_reg    <= a_err;
            end
        end
    end

    // Build the response entry from the inflight record and the SRAM read data.
    always_comb begin
        push_entry          = '0;
        push_entry.d_opcode = infl_get_reg ? AccessAckData : AccessAck;
        push_entry.d_size   = infl_size_reg;
        push_entry.d_source = infl_source_reg;
        push_entry.d_error  = infl_err_reg;
        push_entry.d_data   = (infl_get_reg && !infl_err_reg) ? rdata_i : 32'h0;
    end

    tlul_sram_dev_rspfifo #(
        .Depth (Outstanding)
    ) u_rspfifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (infl_valid_reg),
        .push_data_i (push_entry),
        .ready_i     (tl_i.d_ready),
        .valid_o     (rsp_valid),
        .data_o      (rsp_head),
        .count_o     (fifo_count)
    );

    // D channel driven from the queue head; constant fields tied off.
    always_comb begin
        tl_o          = '0;
        tl_o.a_ready  = a_ready;
        tl_o.d_valid  = rsp_valid;
        tl_o.d_opcode = rsp_head.d_opcode;
        tl_o.d_param  = 3'b000;
        tl_o.d_size   = rsp_head.d_size;
        tl_o.d_source = rsp_head.d_source;
        tl_o.d_sink   = 1'b0;
        tl_o.d_data   = rsp_head.d_data;
        tl_o.d_user   = TL_D_USER_DEFAULT;
        tl_o.d_error  = rsp_head.d_error;
    end

endmodule
